ad9958_ftw_sequencer: RTL and testbench

//   Sequences the AD9958 two-channel DDS serial port. After reset, pulses the DDS

---
 rtl/ad9958_ftw_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_ad9958_ftw_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9958_ftw_sequencer.sv
// AD9958 serial-port sequencer: pulses MASTER_RESET after reset, then for each
// accepted FTW pair writes CSR/FTW frames for both channels and strobes IO_UPDATE.
module ad9958_ftw_sequencer #(
    parameter int CLK_DIV     = 2,
    parameter int CS_GAP      = 2,
    parameter int IOUP_CYCLES = 4,
    parameter int MRST_CYCLES = 16,
    parameter int MRST_WAIT   = 32
) (
    input  logic        Sync_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] ftw0,
    input  logic [31:0] ftw1,
    output logic        busy,
    output logic        done,
    output logic        dds_mrst,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_sdio,
    output logic        io_update
);

    typedef enum logic [2:0] {
        ST_MRST, ST_MWAIT, ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP, ST_IOUP, ST_DONE
    } state_e;

    // Outputs are registered from the next state, so the first MRST cycle after
    // reset still shows dds_mrst low; leaving at count MRST_CYCLES keeps the pulse exact.
    localparam logic [15:0] MRST_LAST = 16'(MRST_CYCLES);
    localparam logic [15:0] WAIT_LAST = 16'(MRST_WAIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);
    localparam logic [15:0] IOUP_LAST = 16'(IOUP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sclk_hi_q, sclk_hi_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  frame_q, frame_d;
    logic [39:0] sreg_q, sreg_d;
    logic [31:0] ftw0_q, ftw0_d;
    logic [31:0] ftw1_q, ftw1_d;
    logic [39:0] frame_word;
    logic [5:0]  frame_bits;

    logic req_ready_q, req_ready_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic dds_mrst_q, dds_mrst_d;
    logic cs_n_q, cs_n_d;
    logic sclk_q, sclk_d;
    logic sdio_q, sdio_d;
    logic io_update_q, io_update_d;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values computed before this edge regardless of block order.
    always_ff @(posedge Sync_clk) begin
        if (reset) begin
            state_q     <= ST_MRST;
            cnt_q       <= '0;
            sclk_hi_q   <= 1'b0;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            sreg_q      <= '0;
            ftw0_q      <= '0;
            ftw1_q      <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            dds_mrst_q  <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            sdio_q      <= 1'b0;
            io_update_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sclk_hi_q   <= sclk_hi_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            sreg_q      <= sreg_d;
            ftw0_q      <= ftw0_d;
            ftw1_q      <= ftw1_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dds_mrst_q  <= dds_mrst_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            sdio_q      <= sdio_d;
            io_update_q <= io_update_d;
        end
    end

    // Frame contents, MSB-aligned in a 40-bit word: instruction byte then data.
    always_comb begin
        frame_word = 40'h0;
        frame_bits = 6'd16;
        case (frame_q)
            2'd0:    frame_word = {16'h0040, 24'h0};
            2'd1:    begin frame_word = {8'h04, ftw0_q}; frame_bits = 6'd40; end
            2'd2:    frame_word = {16'h0080, 24'h0};
            default: begin frame_word = {8'h04, ftw1_q}; frame_bits = 6'd40; end
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sclk_hi_d = sclk_hi_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        sreg_d    = sreg_q;
        ftw0_d    = ftw0_q;
        ftw1_d    = ftw1_q;
        case (state_q)
            ST_MRST: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == MRST_LAST) begin
                    state_d = ST_MWAIT;
                    cnt_d   = '0;
                end
            end
            ST_MWAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    ftw0_d  = ftw0;
                    ftw1_d  = ftw1;
                    frame_d = 2'd0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sreg_d    = frame_word;
                bit_cnt_d = frame_bits;
                cnt_d     = '0;
                sclk_hi_d = 1'b0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    sclk_hi_d = ~sclk_hi_q;
                    // End of a high half: sclk falls and the next bit moves out together.
                    if (sclk_hi_q) begin
                        if (bit_cnt_q == 6'd1) begin
                            state_d = ST_GAP;
                        end else begin
                            sreg_d    = {sreg_q[38:0], 1'b0};
                            bit_cnt_d = bit_cnt_q - 6'd1;
                        end
                    end
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (frame_q == 2'd3) begin
                        state_d = ST_IOUP;
                    end else begin
                        frame_d = frame_q + 2'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_IOUP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == IOUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_MRST;
        endcase
    end

    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        dds_mrst_d  = (state_d == ST_MRST);
        cs_n_d      = (state_d != ST_SHIFT);
        sclk_d      = (state_d == ST_SHIFT) && sclk_hi_d;
        sdio_d      = (state_d == ST_SHIFT) && sreg_d[39];
        io_update_d = (state_d == ST_IOUP);
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dds_mrst  = dds_mrst_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_sclk  = sclk_q;
    assign spi_sdio  = sdio_q;
    assign io_update = io_update_q;

endmodule

// File: tb/tb_ad9958_ftw_sequencer.sv
// Bench for ad9958_ftw_sequencer: a default build and a CLK_DIV=1/CS_GAP=1 build
// share one SPI monitor that decodes frames against a scoreboard queue.
module tb_ad9958_ftw_sequencer;

    localparam int MRST = 16;
    localparam int MWAIT = 32;
    localparam int IOUP = 4;
    localparam int CD0 = 2;
    localparam int GAP0 = 2;
    localparam int CD1 = 1;
    localparam int GAP1 = 1;

    typedef struct packed {
        logic [39:0] data;
        logic [5:0]  bits;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        tb_valid;
    logic [31:0] tb_ftw0, tb_ftw1;
    logic [1:0]  valid, ready, busy, done, mrst, cs_n, sclk, sdio, ioup;
    logic        m_ready, m_busy, m_done, m_mrst, m_cs_n, m_sclk, m_sdio, m_io;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    frame_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign valid   = sel ? {tb_valid, 1'b0} : {1'b0, tb_valid};
    assign m_ready = ready[sel];
    assign m_busy  = busy[sel];
    assign m_done  = done[sel];
    assign m_mrst  = mrst[sel];
    assign m_cs_n  = cs_n[sel];
    assign m_sclk  = sclk[sel];
    assign m_sdio  = sdio[sel];
    assign m_io    = ioup[sel];

    ad9958_ftw_sequencer #(
        .CLK_DIV(CD0), .CS_GAP(GAP0), .IOUP_CYCLES(IOUP), .MRST_CYCLES(MRST), .MRST_WAIT(MWAIT)
    ) u_dut (
        .Sync_clk(clk), .reset(rst), .req_valid(valid[0]), .req_ready(ready[0]),
        .ftw0(tb_ftw0), .ftw1(tb_ftw1), .busy(busy[0]), .done(done[0]), .dds_mrst(mrst[0]),
        .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]), .spi_sdio(sdio[0]), .io_update(ioup[0])
    );

    ad9958_ftw_sequencer #(
        .CLK_DIV(CD1), .CS_GAP(GAP1), .IOUP_CYCLES(IOUP), .MRST_CYCLES(MRST), .MRST_WAIT(MWAIT)
    ) u_dut_fast (
        .Sync_clk(clk), .reset(rst), .req_valid(valid[1]), .req_ready(ready[1]),
        .ftw0(tb_ftw0), .ftw1(tb_ftw1), .busy(busy[1]), .done(done[1]), .dds_mrst(mrst[1]),
        .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]), .spi_sdio(sdio[1]), .io_update(ioup[1])
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int cur_cd();
        return sel ? CD1 : CD0;
    endfunction

    function automatic int cur_gap();
        return sel ? GAP1 : GAP0;
    endfunction

    // Accept-IDLE to next IDLE; done is the last cycle of that span.
    function automatic int span();
        return 4 + 224 * cur_cd() + 4 * cur_gap() + IOUP + 2;
    endfunction

    // ---------------- SPI / strobe monitor (samples on falling edge) ----------------
    logic        in_frame = 1'b0;
    logic [39:0] shreg;
    int nbits, viol, per_err, last_rise, stray, frames_in_req;
    int io_start, io_fall, io_rise_cnt, done_start, done_cnt, acc_cnt, overlap;
    logic p_sclk = 1'b0, p_sdio = 1'b0, p_cs_n = 1'b1, p_io = 1'b0, p_done = 1'b0;
    frame_t e;

    initial begin
        nbits = 0; viol = 0; per_err = 0; last_rise = 0; stray = 0; frames_in_req = 0;
        io_start = 0; io_fall = 0; io_rise_cnt = 0; done_start = 0; done_cnt = 0;
        acc_cnt = 0; overlap = 0; shreg = '0;
    end

    always @(negedge clk) begin
        if (rst) begin
            in_frame      = 1'b0;
            frames_in_req = 0;
        end else begin
            if (tb_valid && m_ready) begin
                acc_cnt++;
                if (m_done) overlap++;
            end
            if (m_sclk && !p_sclk && m_cs_n) stray++;
            if (p_cs_n && !m_cs_n) begin
                in_frame = 1'b1;
                nbits = 0; shreg = '0; viol = 0; per_err = 0;
                frames_in_req++;
            end
            if (in_frame && !m_cs_n) begin
                if (m_sclk && (m_sdio != p_sdio)) viol++;
                if (m_sclk && !p_sclk) begin
                    if (nbits > 0 && (cyc - last_rise) != 2 * cur_cd()) per_err++;
                    last_rise = cyc;
                    shreg = {shreg[38:0], m_sdio};
                    nbits++;
                end
            end
            if (in_frame && m_cs_n) begin
                in_frame = 1'b0;
                check("frame_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("frame_bits", 64'(nbits), 64'(e.bits));
                    check("frame_data", 64'(shreg), 64'(e.data));
                    check("sdio_stable", 64'(viol), 64'(0));
                    check("sclk_period", 64'(per_err), 64'(0));
                end
            end
            if (m_io && !p_io) begin
                io_start = cyc;
                io_rise_cnt++;
            end
            if (!m_io && p_io) begin
                io_fall = cyc;
                check("ioup_width", 64'(cyc - io_start), 64'(IOUP));
            end
            if (m_done && !p_done) begin
                done_start = cyc;
                done_cnt++;
                check("done_after_ioup", 64'(cyc), 64'(io_fall));
                check("frames_per_req", 64'(frames_in_req), 64'(4));
                check("stray_sclk", 64'(stray), 64'(0));
                frames_in_req = 0;
            end
            if (!m_done && p_done) check("done_width", 64'(cyc - done_start), 64'(1));
        end
        p_sclk = m_sclk; p_sdio = m_sdio; p_cs_n = m_cs_n; p_io = m_io; p_done = m_done;
    end

    // ---------------- stimulus helpers (drive and sample 1 time unit after posedge) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back('{data: 40'h40, bits: 6'd16});
        exp_q.push_back('{data: {8'h04, a}, bits: 6'd40});
        exp_q.push_back('{data: 40'h80, bits: 6'd16});
        exp_q.push_back('{data: {8'h04, b}, bits: 6'd40});
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit hold, output int acc);
        tb_ftw0 = a; tb_ftw1 = b; tb_valid = 1'b1; acc = -1;
        for (int i = 0; i < 1000; i++) begin
            if (m_ready) begin
                acc = cyc;
                break;
            end
            tick();
        end
        check("accept_seen", 64'(acc >= 0), 64'(1));
        tick();
        if (!hold) tb_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 2000; i++) begin
            if (m_done) begin
                dc = cyc;
                break;
            end
            tick();
        end
        check("done_seen", 64'(dc >= 0), 64'(1));
    endtask

    task automatic run_req(input logic [31:0] a, input logic [31:0] b);
        int acc, dc;
        push_req(a, b);
        send(a, b, 1'b0, acc);
        wait_done(dc);
        check("accept_to_done", 64'(dc - acc), 64'(span() - 1));
        tick();
        check("ready_after_done", 64'(m_ready), 64'(1));
    endtask

    // dds_mrst pulse width after release, then MWAIT idle cycles before ready.
    task automatic check_init();
        int t_rise, t_fall, t_rdy;
        t_rise = -1; t_fall = -1; t_rdy = -1;
        for (int i = 0; i < 200; i++) begin
            if (m_mrst && t_rise < 0) t_rise = cyc;
            if (!m_mrst && t_rise >= 0 && t_fall < 0) t_fall = cyc;
            if (m_ready) begin
                t_rdy = cyc;
                break;
            end
            tick();
        end
        check("mrst_width", 64'(t_fall - t_rise), 64'(MRST));
        check("mwait_to_ready", 64'(t_rdy - t_fall), 64'(MWAIT));
    endtask

    initial begin
        int acc1, acc2, dc, dc2, acc_before, d_before, io_before;
        bit found;
        rst = 1'b1; sel = 1'b0; tb_valid = 1'b0; tb_ftw0 = '0; tb_ftw1 = '0;
        repeat (3) tick();
        check("reset_outputs", 64'({m_ready, m_busy, m_done, m_mrst, m_cs_n, m_sclk, m_sdio, m_io}),
              64'(8'b0100_1000));
        rst = 1'b0;
        check_init();

        run_req(32'h1234_5678, 32'h9ABC_DEF0);
        run_req(32'hFFFF_FFFF, 32'h0000_0000);
        run_req($urandom, $urandom);

        // valid held through the transfer with changing data; second pair taken after done
        acc_before = acc_cnt;
        push_req(32'hA5A5_0F0F, 32'h3C3C_C3C3);
        send(32'hA5A5_0F0F, 32'h3C3C_C3C3, 1'b1, acc1);
        for (int i = 0; i < 100; i++) begin
            tb_ftw0 = $urandom; tb_ftw1 = $urandom;
            tick();
        end
        tb_ftw0 = 32'h0BAD_F00D; tb_ftw1 = 32'hCAFE_BABE;
        push_req(32'h0BAD_F00D, 32'hCAFE_BABE);
        wait_done(dc);
        check("b2b_single_accept", 64'(acc_cnt - acc_before), 64'(1));
        check("b2b_ready_at_done", 64'(m_ready), 64'(0));
        check("b2b_first_latency", 64'(dc - acc1), 64'(span() - 1));
        tick();
        check("b2b_ready_after_done", 64'(m_ready), 64'(1));
        acc2 = cyc;
        tick();
        tb_valid = 1'b0;
        wait_done(dc2);
        check("b2b_second_latency", 64'(dc2 - acc2), 64'(span() - 1));
        tick();

        // reset in the middle of F1: bus idles at once, init repeats, no strobes
        push_req(32'h1357_9BDF, 32'h2468_ACE0);
        send(32'h1357_9BDF, 32'h2468_ACE0, 1'b0, acc1);
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (frames_in_req == 2 && nbits == 20) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("reached_f1_bit20", 64'(found), 64'(1));
        rst = 1'b1;
        exp_q.delete();
        d_before = done_cnt; io_before = io_rise_cnt;
        tick();
        check("mid_reset_bus", 64'({m_cs_n, m_sclk, m_io, m_busy}), 64'(4'b1001));
        rst = 1'b0;
        check_init();
        check("no_done_after_abort", 64'(done_cnt), 64'(d_before));
        check("no_ioup_after_abort", 64'(io_rise_cnt), 64'(io_before));
        run_req(32'h1234_5678, 32'h9ABC_DEF0);

        // CLK_DIV=1, CS_GAP=1 build
        sel = 1'b1;
        tick();
        run_req(32'h1234_5678, 32'h9ABC_DEF0);
        run_req($urandom, $urandom);

        check("done_accept_overlap", 64'(overlap), 64'(0));
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
